uart_wb_master: RTL
===================

# uart_wb_master

Debug/bring-up bridge that turns 8N1 serial command frames into single Wishbone classic bus cycles. It is the initiator counterpart of the accelerator's Wishbone responder and drives the accelerator's `wb_*` slave port from a host UART when the management core is not driving it. Each command produces exactly one bus cycle and one serial response.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (≥4).
- `TIMEOUT_CYCLES`, 1024, maximum cycles a bus cycle waits for ack (used only with the timeout feature).

Ports:
- `wb_clk_i` input 1: sole clock, all logic on the rising edge.
- `wb_rst_i` input 1: synchronous, active-high reset.
- `ser_rx` input 1: UART receive, idle high, asynchronous to `wb_clk_i`.
- `ser_tx` output 1: UART transmit, idle high.
- `ser_tx_oeb` output 1: pad output-enable bar; 1 in reset, 0 otherwise.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` output 1 each: Wishbone master strobes.
- `wbm_adr_o` output 32: byte address.
- `wbm_dat_o` output 32: write data.
- `wbm_sel_o` output 4: byte selects, always 4'hF.
- `wbm_dat_i` input 32: read data.
- `wbm_ack_i` input 1: slave acknowledge.
- `busy` output 1: high from first command byte until last response stop bit ends.

## Operation
- Frame formats (multi-byte fields MSB byte first): write = 0x57, ADR[4], DAT[4]; read = 0x52, ADR[4].
- Responses: write ack → 0x4B; read ack → DAT[4], MSB first; timeout → 0x45 (single byte, both commands).
- Any other first byte: discarded, no response, parser stays in IDLE.
- RX: 2-flop synchronizer; start detected on a synchronized falling edge; bits sampled at mid-bit (CLKS_PER_BIT/2 after edge, then every CLKS_PER_BIT); LSB first. Stop bit sampled 0 = framing error: byte dropped, parser returns to IDLE, partial frame discarded.
- Parser FSM: IDLE → ADDR (4 bytes) → DATA (4 bytes, write only) → BUS → RESP → IDLE.
- Bytes completing while in BUS or RESP are discarded.
- BUS: `wbm_cyc_o`=`wbm_stb_o`=1, `wbm_we_o`=1 for write; address/data/we held stable until ack or timeout.
- TX: 1 start, 8 data LSB first, 1 stop, each CLKS_PER_BIT cycles; multi-byte responses back-to-back with no idle gap.

## Timing
- Reset values: `ser_tx`=1, `ser_tx_oeb`=1, `wbm_cyc_o`=`wbm_stb_o`=`wbm_we_o`=0, `wbm_adr_o`=`wbm_dat_o`=0, `wbm_sel_o`=4'hF, `busy`=0.
- `wbm_cyc_o`/`wbm_stb_o` rise the cycle after the last frame byte's stop-bit sample.
- Ack sampled high in cycle N: `wbm_dat_i` latched in N; `cyc`/`stb` low in N+1; `ser_tx` start bit (low) begins N+1.
- Ack asserted in the same cycle `stb` first rises is valid (zero-wait-state slave).
- `wbm_ack_i` outside BUS is ignored.
- `busy` falls the cycle after the final stop bit completes; a new start bit is then accepted.
- Reset mid-operation: bus cycle is dropped immediately (`cyc`/`stb` low next cycle), TX aborts with `ser_tx` high, partial frame discarded.

## Configuration
- `UART_WB_MASTER_TIMEOUT_EN` defined: a counter starts when `stb` rises; if ack is not seen in TIMEOUT_CYCLES cycles, `cyc`/`stb` drop next cycle and 0x45 is sent.
- Not defined: no counter, BUS waits indefinitely for ack; 0x45 is never sent.

## Test plan
(Bench uses CLKS_PER_BIT=4, TIMEOUT_CYCLES=16.)
- Write 0x57,30,00,00,04,DE,AD,BE,EF with 1-cycle-late ack → one cycle with adr=0x30000004, dat=0xDEADBEEF, we=1, sel=F; TX 0x4B.
- Read 0x52,30,00,00,08, slave returns 0x12345678 zero-wait → we=0, `cyc`/`stb` asserted exactly 1 cycle; TX 0x12,0x34,0x56,0x78 back-to-back.
- Garbage byte 0xAA then valid read → no bus cycle, no response for 0xAA; read completes normally.
- Framing error (stop=0) on 3rd address byte, then a full write → first frame dropped, only the write executes.
- Timeout-enabled build, read with ack held low → `stb` drops after 16 cycles, TX 0x45, `busy` clears; timeout-disabled build → `stb` stays high and `busy` remains high.
- Reset asserted during BUS and during TX → next cycle `cyc`=0, `ser_tx`=1, `ser_tx_oeb`=1; a following write works normally.

Source files
------------

// File: rtl/uart_wb_master.sv
`timescale 1ns/1ps
// uart_wb_master: 8N1 command frames (W/R) become one Wishbone classic cycle each; a serial response follows.
// Bus cycle starts the cycle after the last stop-bit sample; ack timeout enabled by `UART_WB_MASTER_TIMEOUT_EN.
module uart_wb_master #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        ser_tx_oeb,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_TOUT = 8'h45;

  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic          r_rx_act;
  logic [3:0]    r_rx_idx;
  logic [CW-1:0] r_rx_cnt;
  logic [7:0]    r_rx_sh;
  logic          w_rx_tick, w_rx_done, w_rx_ferr;

  logic [2:0]    r_state;
  logic [1:0]    r_bcnt;
  logic          r_we;
  logic          r_cyc;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic [23:0]   r_resp;
  logic [1:0]    r_left;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_idx;
  logic [7:0]    r_tx_sh;
  logic          r_tx;
  logic          r_oeb;
  logic          w_timeout;

  // RX: the third flop only serves falling-edge detection on the synchronized line
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_act <= 1'b0;
      r_rx_idx <= 4'd0;
      r_rx_cnt <= '0;
      r_rx_sh  <= 8'h00;
    end else begin
      r_rx_s1 <= ser_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (!r_rx_act) begin
        if (r_rx_s3 && !r_rx_s2) begin
          r_rx_act <= 1'b1;
          r_rx_cnt <= C_HALF;
          r_rx_idx <= 4'd0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - CW'(1);
      end else begin
        r_rx_cnt <= C_FULL;
        if (r_rx_idx == 4'd0) begin
          if (r_rx_s2) r_rx_act <= 1'b0;
          else         r_rx_idx <= 4'd1;
        end else if (r_rx_idx <= 4'd8) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_idx <= r_rx_idx + 4'd1;
        end else begin
          r_rx_act <= 1'b0;
        end
      end
    end
  end

  assign w_rx_tick = r_rx_act && (r_rx_cnt == '0) && (r_rx_idx == 4'd9);
  assign w_rx_done = w_rx_tick && r_rx_s2;
  assign w_rx_ferr = w_rx_tick && !r_rx_s2;

`ifdef UART_WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (r_state != S_BUS)) r_to_cnt <= '0;
    else                                r_to_cnt <= r_to_cnt + TW'(1);
  end

  assign w_timeout = (r_state == S_BUS) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_bcnt   <= 2'd0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_adr    <= 32'h0;
      r_dat    <= 32'h0;
      r_resp   <= 24'h0;
      r_left   <= 2'd0;
      r_tx_cnt <= '0;
      r_tx_idx <= 4'd0;
      r_tx_sh  <= 8'h00;
      r_tx     <= 1'b1;
      r_oeb    <= 1'b1;
    end else begin
      r_oeb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rx_done && (r_rx_sh == CMD_WR || r_rx_sh == CMD_RD)) begin
            r_we    <= (r_rx_sh == CMD_WR);
            r_bcnt  <= 2'd0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_rx_ferr) begin
            r_state <= S_IDLE;
          end else if (w_rx_done) begin
            r_adr  <= {r_adr[23:0], r_rx_sh};
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_bcnt <= 2'd0;
              if (r_we) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_BUS;
                r_cyc   <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (w_rx_ferr) begin
            r_state <= S_IDLE;
          end else if (w_rx_done) begin
            r_dat  <= {r_dat[23:0], r_rx_sh};
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_state <= S_BUS;
              r_cyc   <= 1'b1;
            end
          end
        end
        S_BUS: begin
          // start bit goes out in the same edge that drops cyc/stb
          if (wbm_ack_i || w_timeout) begin
            r_cyc    <= 1'b0;
            r_state  <= S_RESP;
            r_tx     <= 1'b0;
            r_tx_cnt <= C_FULL;
            r_tx_idx <= 4'd0;
            if (!wbm_ack_i) begin
              r_tx_sh <= RSP_TOUT;
              r_left  <= 2'd0;
            end else if (r_we) begin
              r_tx_sh <= RSP_ACK;
              r_left  <= 2'd0;
            end else begin
              r_tx_sh <= wbm_dat_i[31:24];
              r_resp  <= wbm_dat_i[23:0];
              r_left  <= 2'd3;
            end
          end
        end
        S_RESP: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - CW'(1);
          end else begin
            r_tx_cnt <= C_FULL;
            if (r_tx_idx <= 4'd7) begin
              r_tx     <= r_tx_sh[0];
              r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
              r_tx_idx <= r_tx_idx + 4'd1;
            end else if (r_tx_idx == 4'd8) begin
              r_tx     <= 1'b1;
              r_tx_idx <= 4'd9;
            end else if (r_left != 2'd0) begin
              // next response byte starts right after this stop bit
              r_left   <= r_left - 2'd1;
              r_tx_sh  <= r_resp[23:16];
              r_resp   <= {r_resp[15:0], 8'h00};
              r_tx     <= 1'b0;
              r_tx_idx <= 4'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ser_tx     = r_tx;
  assign ser_tx_oeb = r_oeb;
  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_cyc;
  assign wbm_we_o   = r_cyc & r_we;
  assign wbm_adr_o  = r_adr;
  assign wbm_dat_o  = r_dat;
  assign wbm_sel_o  = 4'hF;
  assign busy       = (r_state != S_IDLE);

endmodule
